// File: rtl/systolic_matmul_sequencer_pkg.sv
// Shared definitions for the systolic matmul sequencer.
//   N              : grid dimension (8x8 boolean OR-of-AND array)
//   WAVEFRONTS     : skewed issue cycles needed to feed every A/B term
//   READOUT_CYCLES : cycles the grid needs to shift out all result rows
//   mat_t          : 8x8 bit matrix, m[row][col]
//   state_t        : sequencer states
package systolic_matmul_sequencer_pkg;

    localparam int N              = 8;
    localparam int WAVEFRONTS     = 2 * N - 1;
    localparam int READOUT_CYCLES = 2 * N;

    typedef logic [N-1:0][N-1:0] mat_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        DRAIN   = 3'd2,
        READOUT = 3'd3,
        DELIVER = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_matmul_sequencer_skew.sv
// Combinational wavefront generator for the systolic grid edges.
// Ports:
//   a, b : operand matrices, a[i][k], b[k][j]
//   t    : wavefront index (0..14 during issue)
//   in1  : column-edge bus, in1[j] = b[t-j][j]
//   in2  : row-edge bus,    in2[i] = a[i][t-i]
// Terms whose derived index falls outside 0..N-1 drive 0.
module systolic_skew
    import systolic_matmul_sequencer_pkg::*;
(
    input  mat_t         a,
    input  mat_t         b,
    input  logic [4:0]   t,
    output logic [N-1:0] in1,
    output logic [N-1:0] in2
);

    logic [4:0] diff;

    always_comb begin
        in1  = '0;
        in2  = '0;
        diff = '0;
        for (int i = 0; i < N; i++) begin
            diff = t - 5'(i);
            if ((t >= 5'(i)) && (diff < 5'(N))) begin
                in2[i] = a[i][diff[2:0]];
                in1[i] = b[diff[2:0]][i];
            end
        end
    end

endmodule

// File: rtl/systolic_matmul_sequencer.sv
// Host-side sequencer for the 8x8 boolean systolic grid.
// Stores A and B from host row loads, issues skewed wavefronts, drains the
// pipeline, runs the grid readout, captures C and hands it back row by row.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   ld_valid/ld_ready          : row load handshake (ready only in IDLE)
//   ld_sel, ld_row, ld_data    : 0=A/1=B, row index, row bits
//   start, busy                : begin multiply (IDLE only), not-IDLE flag
//   arr_in1, arr_in2           : grid column-edge / row-edge buses
//   arr_readout, arr_out       : grid readout enable, grid bottom-row output
//   res_valid/res_ready        : result row handshake
//   res_row, res_data          : presented result row index and bits
//   done                       : one-cycle pulse after the last row is taken
// All outputs are flops loaded from next-state values, so there is no
// combinational input-to-output path.
module systolic_matmul_sequencer
    import systolic_matmul_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic         ld_sel,
    input  logic [2:0]   ld_row,
    input  logic [N-1:0] ld_data,
    input  logic         start,
    output logic         busy,
    output logic [N-1:0] arr_in1,
    output logic [N-1:0] arr_in2,
    output logic         arr_readout,
    input  logic [N-1:0] arr_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [2:0]   res_row,
    output logic [N-1:0] res_data,
    output logic         done
);

    state_t       state_q, state_d;
    logic [4:0]   phase_q, phase_d;
    logic [2:0]   row_q, row_d;
    mat_t         a_q, a_d, b_q, b_d, c_q, c_d;

    logic [N-1:0] arr_in1_q, arr_in1_d, arr_in2_q, arr_in2_d;
    logic         arr_readout_q, arr_readout_d;
    logic         res_valid_q, res_valid_d;
    logic [2:0]   res_row_q, res_row_d;
    logic [N-1:0] res_data_q, res_data_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         ld_ready_q, ld_ready_d;

    logic [N-1:0] skew_in1, skew_in2;

    // Driven from the next-cycle matrices and phase so that the registered
    // edge buses line up with ISSUE cycle t, and a load coinciding with
    // start is already visible in the first wavefront.
    systolic_skew u_skew (
        .a   (a_d),
        .b   (b_d),
        .t   (phase_d),
        .in1 (skew_in1),
        .in2 (skew_in2)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 5'd1;
        row_d   = row_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (ld_valid && ld_ready_q) begin
                    if (ld_sel) b_d[ld_row] = ld_data;
                    else        a_d[ld_row] = ld_data;
                end
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                if (phase_q == 5'(WAVEFRONTS - 1)) begin
                    state_d = DRAIN;
                    phase_d = '0;
                end
            end
            DRAIN: begin
                if (phase_q == 5'(DRAIN_CYCLES - 1)) begin
                    state_d = READOUT;
                    phase_d = '0;
                end
            end
            READOUT: begin
                // r = phase+1; even r=2m+2 presents C[7-m], i.e. ~phase[3:1].
                if (phase_q[0]) c_d[~phase_q[3:1]] = arr_out;
                if (phase_q == 5'(READOUT_CYCLES - 1)) begin
                    state_d = DELIVER;
                    phase_d = '0;
                    row_d   = '0;
                end
            end
            DELIVER: begin
                phase_d = '0;
                if (res_valid_q && res_ready) begin
                    if (row_q == 3'd7) begin
                        state_d = IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        arr_in1_d     = (state_d == ISSUE) ? skew_in1 : '0;
        arr_in2_d     = (state_d == ISSUE) ? skew_in2 : '0;
        arr_readout_d = (state_d == READOUT);
        res_valid_d   = (state_d == DELIVER);
        res_row_d     = row_d;
        res_data_d    = (state_d == DELIVER) ? c_d[row_d] : '0;
        busy_d        = (state_d != IDLE);
        ld_ready_d    = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            row_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            arr_in1_q     <= '0;
            arr_in2_q     <= '0;
            arr_readout_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_row_q     <= '0;
            res_data_q    <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            ld_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            row_q         <= row_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            arr_in1_q     <= arr_in1_d;
            arr_in2_q     <= arr_in2_d;
            arr_readout_q <= arr_readout_d;
            res_valid_q   <= res_valid_d;
            res_row_q     <= res_row_d;
            res_data_q    <= res_data_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            ld_ready_q    <= ld_ready_d;
        end
    end

    assign arr_in1     = arr_in1_q;
    assign arr_in2     = arr_in2_q;
    assign arr_readout = arr_readout_q;
    assign res_valid   = res_valid_q;
    assign res_row     = res_row_q;
    assign res_data    = res_data_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign ld_ready    = ld_ready_q;

endmodule

// File: tb/tb_systolic_matmul_sequencer.sv
module tb_systolic_matmul_sequencer;
    import systolic_matmul_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ld_valid = 1'b0, ld_sel = 1'b0, start = 1'b0, res_ready = 1'b0;
    logic [2:0] ld_row = '0;
    logic [7:0] ld_data = '0;
    logic       ld_ready, busy, arr_readout, res_valid, done;
    logic [7:0] arr_in1, arr_in2, arr_out, res_data;
    logic [2:0] res_row;

    int checks = 0;
    int errors = 0;

    mat_t tb_a = '0, tb_b = '0;
    logic [10:0] sb_q[$];

    logic [4:0] sk_t = '0;
    logic [7:0] sk_in1, sk_in2;

    always #5 clk = ~clk;

    systolic_matmul_sequencer #(.DRAIN_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_row(ld_row), .ld_data(ld_data), .start(start),
        .busy(busy), .arr_in1(arr_in1), .arr_in2(arr_in2),
        .arr_readout(arr_readout), .arr_out(arr_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_row(res_row), .res_data(res_data), .done(done)
    );

    systolic_skew u_ref_skew (.a(tb_a), .b(tb_b), .t(sk_t), .in1(sk_in1), .in2(sk_in2));

    // Behavioural 8x8 grid: A flows right, B flows down, each PE ORs in a&b.
    // Readout presents row 7-m for readout cycles 2m+1..2m+2; accumulators
    // clear once readout ends.
    logic       g_a [8][8];
    logic       g_b [8][8];
    logic [7:0] g_acc [8];
    logic       g_ai, g_bi;
    int         rd_cnt;

    always @(posedge clk) begin
        if (reset) begin
            rd_cnt <= 0;
            for (int i = 0; i < 8; i++) begin
                g_acc[i] <= 8'h00;
                for (int j = 0; j < 8; j++) begin
                    g_a[i][j] <= 1'b0;
                    g_b[i][j] <= 1'b0;
                end
            end
        end else begin
            if (arr_readout) rd_cnt <= rd_cnt + 1;
            else             rd_cnt <= 0;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    if (j == 0) g_ai = arr_in2[i];
                    else        g_ai = g_a[i][j-1];
                    if (i == 0) g_bi = arr_in1[j];
                    else        g_bi = g_b[i-1][j];
                    g_a[i][j] <= g_ai;
                    g_b[i][j] <= g_bi;
                    if (!arr_readout && rd_cnt != 0) g_acc[i][j] <= 1'b0;
                    else g_acc[i][j] <= g_acc[i][j] | (g_ai & g_bi);
                end
            end
        end
    end

    always_comb begin
        arr_out = 8'h00;
        if (arr_readout && rd_cnt < 16) arr_out = g_acc[7 - rd_cnt / 2];
    end

    function automatic mat_t matmul(input mat_t a, input mat_t b);
        mat_t c = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                for (int k = 0; k < 8; k++)
                    c[i][j] = c[i][j] | (a[i][k] & b[k][j]);
        return c;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_row(input bit sel, input int row, input logic [7:0] data);
        ld_valid = 1'b1; ld_sel = sel; ld_row = 3'(row); ld_data = data;
        if (sel) tb_b[row] = data; else tb_a[row] = data;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic load_all(input mat_t a, input mat_t b);
        for (int r = 0; r < 8; r++) begin
            load_row(1'b0, r, a[r]);
            load_row(1'b1, r, b[r]);
        end
    endtask

    task automatic run_mult(input bit skew_chk, input bit chk_lat, input int bp_row,
                            input bit interfere, input bit with_load, input bit lsel,
                            input int lrow, input logic [7:0] ldat);
        mat_t exp_c;
        int   cyc = 0;
        int   stall = 0;
        int   early_done = 0;
        start = 1'b1;
        if (with_load) begin
            ld_valid = 1'b1; ld_sel = lsel; ld_row = 3'(lrow); ld_data = ldat;
            if (lsel) tb_b[lrow] = ldat; else tb_a[lrow] = ldat;
        end
        exp_c = matmul(tb_a, tb_b);
        for (int k = 0; k < 8; k++) sb_q.push_back({3'(k), exp_c[k]});
        step(); cyc = 1;
        start = 1'b0; ld_valid = 1'b0;
        for (int t = 0; t < 15; t++) begin
            if (skew_chk) begin
                sk_t = 5'(t);
                #1;
                checks++;
                if (arr_in1 !== sk_in1 || arr_in2 !== sk_in2) begin
                    errors++;
                    $display("FAIL skew t=%0d in1=%h in2=%h expected in1=%h in2=%h",
                             t, arr_in1, arr_in2, sk_in1, sk_in2);
                end
            end
            if (interfere && t == 3) begin
                ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 3'd0; ld_data = ~tb_a[0]; start = 1'b1;
                checks++;
                if (ld_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL issue_flags ld_ready=%b busy=%b expected 0 1", ld_ready, busy);
                end
            end
            if (interfere && t == 5) begin ld_valid = 1'b0; start = 1'b0; end
            step(); cyc++;
        end
        ld_valid = 1'b0; start = 1'b0;
        while (!res_valid && cyc < 100) begin step(); cyc++; end
        checks++;
        if (!res_valid) begin
            errors++;
            $display("FAIL first_valid_timeout res_valid=%b after %0d cycles expected 1", res_valid, cyc);
            sb_q.delete();
            return;
        end
        if (chk_lat) begin
            checks++;
            if (cyc != 40) begin
                errors++;
                $display("FAIL latency got %0d cycles expected 40", cyc);
            end
        end
        for (int n = 0; n < 80 && sb_q.size() > 0; n++) begin
            if (done) early_done++;
            if (res_valid) begin
                checks++;
                if ({res_row, res_data} !== sb_q[0]) begin
                    errors++;
                    $display("FAIL result row=%0d data=%h expected row=%0d data=%h",
                             res_row, res_data, sb_q[0][10:8], sb_q[0][7:0]);
                end
                if (int'(res_row) == bp_row && stall < 5) begin
                    res_ready = 1'b0; stall++;
                end else begin
                    res_ready = 1'b1;
                    void'(sb_q.pop_front());
                end
            end else begin
                res_ready = 1'b0;
            end
            step();
        end
        res_ready = 1'b0;
        checks++;
        if (sb_q.size() != 0 || early_done != 0) begin
            errors++;
            $display("FAIL delivery remaining=%0d early_done=%0d expected 0 0", sb_q.size(), early_done);
            sb_q.delete();
        end
        checks++;
        if (done !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b res_valid=%b busy=%b expected 1 0 0", done, res_valid, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_width done=%b ld_ready=%b expected 0 1", done, ld_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b0 || arr_in1 !== 8'h00 || arr_in2 !== 8'h00 ||
            arr_readout !== 1'b0 || res_valid !== 1'b0 || res_row !== 3'd0 ||
            res_data !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset ld_ready=%b busy=%b in1=%h in2=%h rd=%b rv=%b row=%0d data=%h done=%b expected 1 0 00 00 0 0 0 00 0",
                     ld_ready, busy, arr_in1, arr_in2, arr_readout, res_valid, res_row, res_data, done);
        end
    endtask

    task automatic test_identity();
        mat_t a = '0, b;
        logic [7:0] rows [8] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h11, 8'h80};
        for (int r = 0; r < 8; r++) begin a[r] = 8'(1 << r); b[r] = rows[r]; end
        load_all(a, b);
        run_mult(1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic test_single_term();
        mat_t a = '0, b = '0;
        a[0] = 8'h01;
        load_all(a, b);
        // B row 0 lands in the same cycle as start.
        run_mult(1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b1, 0, 8'hA5);
    endtask

    task automatic test_all_ones();
        mat_t ones = '1, zeros = '0;
        load_all(ones, ones);
        run_mult(1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
        for (int r = 0; r < 8; r++) load_row(1'b0, r, zeros[r]);
        run_mult(1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic test_backpressure();
        mat_t a, b;
        for (int r = 0; r < 8; r++) begin
            a[r] = 8'($urandom_range(0, 255)); b[r] = 8'($urandom_range(0, 255));
        end
        load_all(a, b);
        run_mult(1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic test_interference();
        run_mult(1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic test_random_skew();
        mat_t a, b;
        for (int s = 0; s < 20; s++) begin
            for (int r = 0; r < 8; r++) begin
                a[r] = 8'($urandom_range(0, 255)); b[r] = 8'($urandom_range(0, 255));
            end
            load_all(a, b);
            run_mult(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
        end
    endtask

    task automatic test_reset_mid_readout();
        int n = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!arr_readout && n < 60) begin step(); n++; end
        checks++;
        if (!arr_readout) begin
            errors++;
            $display("FAIL readout_timeout arr_readout=%b expected 1", arr_readout);
        end
        for (int k = 0; k < 6; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (arr_readout !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset rd=%b busy=%b ld_ready=%b rv=%b expected 0 0 1 0",
                     arr_readout, busy, ld_ready, res_valid);
        end
        tb_a = '0; tb_b = '0;
        run_mult(1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_identity();
        test_single_term();
        test_all_ones();
        test_backpressure();
        test_interference();
        test_random_skew();
        test_reset_mid_readout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_matmul_sequencer.md
Name: systolic_matmul_sequencer

Overview:
- Host-side driver for the 8x8 boolean OR-of-AND systolic grid, sitting between host loads and the grid edges.
- Stores matrices A and B, loaded row by row.
- Emits the skewed wavefronts onto the grid's row and column edges, waits for the pipeline to drain, then drives the grid's readout phase.
- Deserialises the shifted-out result C = A·B (C[i][j] = OR_k A[i][k]&B[k][j]) and returns it to the host over a valid/ready port.

Parameters:
- DRAIN_CYCLES, 8, number of zero cycles between the last wavefront and the start of readout (minimum 8).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  host load request
- ld_ready  out  1  load accepted when ld_valid&ld_ready; high only in IDLE
- ld_sel  in  1  0 = write A row, 1 = write B row
- ld_row  in  3  row index
- ld_data  in  8  row bits; bit j = M[row][j]
- start  in  1  begin multiply; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- arr_in1  out  8  column-edge bus, bit j feeds grid column j at row 0
- arr_in2  out  8  row-edge bus, bit i feeds grid row i at column 0
- arr_readout  out  1  grid readout enable
- arr_out  in  8  grid bottom-row output, gated to 0 by the grid when readout is low
- res_valid  out  1  result row available
- res_ready  in  1  host accepts result row
- res_row  out  3  index of the presented result row
- res_data  out  8  C[res_row], bit j = C[res_row][j]
- done  out  1  one-cycle pulse after the last result row is accepted

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE; A, B and C stores cleared to 0.
  - arr_in1=arr_in2=0, arr_readout=0, res_valid=0, res_row=0, res_data=0, done=0, busy=0, ld_ready=1.
  - Reset in any state, including mid-operation, aborts immediately with these values in the following cycle.
- All outputs are registered; no combinational path from any input to any output.
- Loads: a write occurs on ld_valid&ld_ready. ld_valid is ignored outside IDLE.
- States: IDLE -> ISSUE(15 cycles) -> DRAIN(DRAIN_CYCLES) -> READOUT(16 cycles) -> DELIVER -> IDLE.
- IDLE:
  - start=1 moves to ISSUE next cycle.
  - A write and start in the same cycle: the write lands and ISSUE uses the updated matrix.
- ISSUE, cycle t=0..14 (t counts from the first ISSUE cycle):
  - arr_in2[i] = A[i][t-i]
  - arr_in1[j] = B[t-j][j]
  - Any term whose index is outside 0..7 drives 0.
  - start is ignored while busy.
- DRAIN: arr_in1 = arr_in2 = 0.
- READOUT:
  - arr_readout=1 for exactly 16 cycles, numbered r=1..16; arr_in1 = arr_in2 = 0.
  - At the end of cycle r=2m+2 (m=0..7), capture arr_out into C[7-m]: r=2 captures C7, r=16 captures C0.
  - arr_readout returns to 0 on the cycle after r=16.
- DELIVER:
  - Present rows in order 0..7: res_valid=1, res_row=k, res_data=C[k].
  - Advance on res_valid&res_ready, holding steady under backpressure.
  - After row 7 is accepted: done=1 for one cycle, res_valid=0, state=IDLE.
- Latency from start to first res_valid: 1 + 15 + DRAIN_CYCLES + 16 cycles (40 with default).
- Counters:
  - 5-bit phase counter, cleared on every state entry.
  - 3-bit row counter, which wraps only by leaving DELIVER.

Decomposition:
- Shared package:
  - N=8, WAVEFRONTS=2N-1=15, READOUT_CYCLES=2N=16.
  - State enum: IDLE, ISSUE, DRAIN, READOUT, DELIVER.
- Sub-module systolic_skew:
  - Combinational; inputs A, B and t.
  - Outputs the wavefront pair (in1, in2) per the ISSUE equations.
  - Reused by the bench's reference model.

Test Plan:
- Identity: A = I (row i = 1<<i), B rows {A5,3C,FF,00,81,7E,11,80} -> C rows equal B rows; done pulses once; first res_valid 40 cycles after start.
- Single term: A row0=01, B row0=A5, all else 0 -> C row0=A5, rows 1..7=00.
- All ones: A=B=FF in all rows -> every C row = FF. Then A all zero with B unchanged -> every C row = 00, proving the stores are reused and the accumulators are cleared by readout.
- Handshake:
  - Backpressure: res_ready held low for 5 cycles on row 3 -> res_row/res_data stable throughout.
  - Interference: ld_valid and start asserted during ISSUE -> ld_ready=0, no write, no restart, C unchanged.
- Reset mid-READOUT (r=7) -> next cycle arr_readout=0, busy=0, ld_ready=1. A subsequent start with cleared stores -> all C rows = 00.
- Skew check: random A, B (≥20 seeds) with the bench comparing arr_in1/arr_in2 every ISSUE cycle against systolic_skew and the final C against the software OR-of-AND product.
